sram_operand_master: RTL and testbench
======================================

# sram_operand_master

Initiator for the 32 KiB x 8 operand SRAM in the SAD datapath. It accepts burst commands (write or read, start address, length), drives the SRAM's address/enable/read-write/data port, and exchanges operand bytes with the rest of the design over valid/ready streams. It absorbs the SRAM's one-cycle read latency with a small skid buffer, so consumer back-pressure never drops data.

## Interface
- ADDR_W, 15, SRAM address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 8, SRAM and stream data width
- LEN_W, 16, burst length width
- Clk  in  1  sole clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Cmd_Valid / Cmd_Ready  in/out  1  command handshake
- Cmd_Write  in  1  1 = write burst, 0 = read burst
- Cmd_Addr  in  ADDR_W  start address
- Cmd_Len  in  LEN_W  byte count; 0 = empty burst
- Wr_Valid / Wr_Ready  in/out  1  write-data stream
- Wr_Data  in  DATA_W  write byte
- Rd_Valid / Rd_Ready  out/in  1  read-data stream
- Rd_Data  out  DATA_W  read byte
- Done  out  1  one-cycle pulse when the burst completes
- Sram_Addr  out  ADDR_W  to SRAM Addr
- Sram_RW  out  1  to SRAM RW (1 = write)
- Sram_En  out  1  to SRAM En
- Sram_Data_In  out  DATA_W  to SRAM Data_In
- Sram_Data_Out  in  DATA_W  from SRAM Data_Out; valid only in the cycle after a read-enabled cycle

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: Cmd_Ready=1. On handshake, latch address and length.
  - Cmd_Len=0: go straight to IDLE with a Done pulse on the next cycle; no SRAM access.
  - Otherwise go to WRITE if Cmd_Write=1, else READ.
- WRITE: Wr_Ready=1. Each Wr handshake registers Sram_En=1, Sram_RW=1, Sram_Addr=current address, Sram_Data_In=Wr_Data for the next cycle. Address then increments with wrap 0x7FFF -> 0x0000, and the remaining count decrements. After the last handshake, return to IDLE.
- READ: issue Sram_En=1, Sram_RW=0 at successive addresses. A read issues only when the skid buffer is guaranteed space at data return. Capture Sram_Data_Out in the cycle after each read-enabled cycle, because the SRAM clears Data_Out otherwise. After the last issue, go to DRAIN.
- DRAIN: wait for all buffered bytes to be accepted, then go to IDLE.
- Skid buffer: 3-entry FIFO, in-order. Rd_Valid = buffer non-empty. Rd_Data = head entry.
- Sram_En=0 whenever no access is scheduled. Sram_Data_In and Sram_Addr hold their last value.
- Reset mid-burst: state returns to IDLE, counters and buffer clear, and the burst is discarded. SRAM contents are untouched.

## Timing
- Reset values: Cmd_Ready=1, Wr_Ready=0, Rd_Valid=0, Rd_Data=0, Done=0, Sram_En=0, Sram_RW=0, Sram_Addr=0, Sram_Data_In=0.
- All Sram_* outputs are registered.
- Command accepted in cycle 0 -> first Sram_En in cycle 1 (write: first Wr handshake in cycle 1 drives Sram_En in cycle 2).
- Read latency: Sram_En read in cycle n -> data captured at end of n+1 -> Rd_Valid in n+2.
- With Rd_Ready held high, reads sustain 1 byte/cycle.
- With Wr_Valid held high, writes sustain 1 byte/cycle.
- Done:
  - Write burst: pulses in the cycle after the last write's Sram_En cycle.
  - Read burst: pulses in the cycle after the last Rd handshake.
  - Cmd_Ready rises in the same cycle as Done.
- Rd_Valid, once high, stays high with stable Rd_Data until the handshake completes.

## Configuration
- SRAM_MASTER_ABORT_EN defined: adds input port Abort (1 bit).
  - Abort=1 in WRITE, READ or DRAIN stops new SRAM accesses from the next cycle.
  - An access already on the bus completes, and its returning read byte is discarded.
  - The skid buffer flushes, state returns to IDLE, and Done pulses one cycle later.
  - Abort in IDLE is ignored.
- Undefined: no Abort port; every burst runs to completion.

## Structure
- Shared package sad_pkg: ADDR_W/DATA_W/LEN_W defaults and the state enum (IDLE, WRITE, READ, DRAIN).
- One sub-module: sram_rd_skid, the 3-entry read FIFO with push, pop, count, and flush.

## Test plan
- Write burst: Addr=0x0010, Len=4, bytes 0xA1..0xA4 back-to-back -> SRAM 0x0010..0x0013 = A1..A4; Sram_En high 4 consecutive cycles; Done one cycle after.
- Read burst of the same region with Rd_Ready=1 -> Rd_Data A1,A2,A3,A4 on consecutive cycles; first Rd_Valid 3 cycles after command accept.
- Read with Rd_Ready toggling 1,0,0,1,... -> no byte lost or duplicated; Sram_En pauses while the buffer is full.
- Wrap-around: write Addr=0x7FFE, Len=3 -> addresses 0x7FFE, 0x7FFF, 0x0000.
- Len=0 -> no Sram_En; Done pulses 1 cycle after accept.
- Rst_n low mid-read-burst -> all outputs at reset values immediately; a new command is accepted after release (with SRAM_MASTER_ABORT_EN: also Abort mid-read -> Done next cycle, Rd_Valid=0).

Source files
------------

// File: rtl/sad_pkg.sv
// Shared definitions for the SAD datapath operand-SRAM master: default
// widths, skid depth and the burst state encoding.
package sad_pkg;

  localparam int SAD_ADDR_W = 15;
  localparam int SAD_DATA_W = 8;
  localparam int SAD_LEN_W  = 16;
  localparam int SKID_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } mstate_e;

endpackage

// File: rtl/sram_rd_skid.sv
// Three-entry in-order read FIFO that absorbs the SRAM's one-cycle read
// latency; Flush empties it and takes priority over push and pop.
module sram_rd_skid
  import sad_pkg::*;
#(
  parameter int W = SAD_DATA_W
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Flush,
  input  logic         Push,
  input  logic [W-1:0] Push_Data,
  input  logic         Pop,
  output logic [W-1:0] Head,
  output logic [1:0]   Count
);

  logic [W-1:0] mem_r [SKID_DEPTH];
  logic [1:0]   wr_ptr_r;
  logic [1:0]   rd_ptr_r;
  logic [1:0]   count_r;
  logic         push_s;
  logic         pop_s;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : (p + 2'd1);
  endfunction

  assign pop_s  = Pop && (count_r != 2'd0);
  assign push_s = Push && ((count_r != 2'd3) || pop_s);

  // Storage, pointers and occupancy
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem_r[i] <= {W{1'b0}};
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 2'd0;
    end else if (Flush) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= Push_Data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign Head  = mem_r[rd_ptr_r];
  assign Count = count_r;

endmodule

// File: rtl/sram_operand_master.sv
// Burst initiator for the 32 KiB x 8 operand SRAM with valid/ready data streams.
// Optional SRAM_MASTER_ABORT_EN adds an Abort input that cancels the active burst.
module sram_operand_master
  import sad_pkg::*;
#(
  parameter int ADDR_W = SAD_ADDR_W,
  parameter int DATA_W = SAD_DATA_W,
  parameter int LEN_W  = SAD_LEN_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic              Cmd_Write,
  input  logic [ADDR_W-1:0] Cmd_Addr,
  input  logic [LEN_W-1:0]  Cmd_Len,
  input  logic              Wr_Valid,
  output logic              Wr_Ready,
  input  logic [DATA_W-1:0] Wr_Data,
  output logic              Rd_Valid,
  input  logic              Rd_Ready,
  output logic [DATA_W-1:0] Rd_Data,
  output logic              Done,
  output logic [ADDR_W-1:0] Sram_Addr,
  output logic              Sram_RW,
  output logic              Sram_En,
  output logic [DATA_W-1:0] Sram_Data_In,
  input  logic [DATA_W-1:0] Sram_Data_Out
`ifdef SRAM_MASTER_ABORT_EN
  , input logic             Abort
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};

  mstate_e           state_r, state_nxt_s;
  logic [ADDR_W-1:0] addr_r, sram_addr_r, cur_addr_s;
  logic [LEN_W-1:0]  rem_r, cur_rem_s;
  logic [DATA_W-1:0] sram_data_r;
  logic              sram_en_r, sram_rw_r, cap_r, done_r;
  logic              issue_s, issue_wr_s, load_s, done_s, flush_s;
  logic              rd_on_bus_s, pop_s, rd_space_s;
  logic [1:0]        skid_count_s;
  logic [2:0]        occ_s;

  assign rd_on_bus_s = sram_en_r && !sram_rw_r;
  assign pop_s       = Rd_Valid && Rd_Ready;
  assign cur_addr_s  = (state_r == IDLE) ? Cmd_Addr : addr_r;
  assign cur_rem_s   = (state_r == IDLE) ? Cmd_Len : rem_r;
  // Worst-case occupancy once every read already on its way has landed; a
  // pop granted this cycle is certain, so it frees its slot for the new issue.
  assign occ_s       = {1'b0, skid_count_s} - {2'b00, pop_s}
                     + {2'b00, rd_on_bus_s} + {2'b00, cap_r};
  assign rd_space_s  = (occ_s < 3'd3);

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state and access-issue decisions
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    issue_wr_s  = 1'b0;
    load_s      = 1'b0;
    done_s      = 1'b0;
    flush_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (Cmd_Valid) begin
          load_s = 1'b1;
          if (Cmd_Len == LEN_ZERO) begin
            done_s = 1'b1;
          end else if (Cmd_Write) begin
            state_nxt_s = WRITE;
          end else begin
            issue_s     = 1'b1;
            state_nxt_s = (Cmd_Len == LEN_ONE) ? DRAIN : READ;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        // Stay one extra cycle after the last handshake so Done trails its Sram_En
        if (rem_r == LEN_ZERO) begin
          state_nxt_s = IDLE;
          done_s      = 1'b1;
        end else if (Wr_Valid) begin
          issue_s    = 1'b1;
          issue_wr_s = 1'b1;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      READ: begin
        if (rem_r == LEN_ZERO) begin
          state_nxt_s = DRAIN;
        end else if (rd_space_s) begin
          issue_s     = 1'b1;
          state_nxt_s = (rem_r == LEN_ONE) ? DRAIN : READ;
        end else begin
          state_nxt_s = READ;
        end
      end
      DRAIN: begin
        if (!rd_on_bus_s && !cap_r && (skid_count_s == {1'b0, pop_s})) begin
          state_nxt_s = IDLE;
          done_s      = 1'b1;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
`ifdef SRAM_MASTER_ABORT_EN
    if (Abort && (state_r != IDLE)) begin
      state_nxt_s = IDLE;
      issue_s     = 1'b0;
      issue_wr_s  = 1'b0;
      done_s      = 1'b1;
      flush_s     = 1'b1;
    end else begin
      flush_s = 1'b0;
    end
`endif
  end

  // Address/count tracking and the registered SRAM port
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_r      <= {ADDR_W{1'b0}};
      rem_r       <= LEN_ZERO;
      sram_addr_r <= {ADDR_W{1'b0}};
      sram_data_r <= {DATA_W{1'b0}};
      sram_en_r   <= 1'b0;
      sram_rw_r   <= 1'b0;
      cap_r       <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r    <= done_s;
      sram_en_r <= issue_s;
      // Read data is only valid the cycle after the enable; an abort discards it
      cap_r     <= rd_on_bus_s && !flush_s;
      if (issue_s) begin
        sram_addr_r <= cur_addr_s;
        sram_rw_r   <= issue_wr_s;
        addr_r      <= cur_addr_s + ADDR_ONE;
        rem_r       <= cur_rem_s - LEN_ONE;
      end else if (load_s) begin
        addr_r <= Cmd_Addr;
        rem_r  <= Cmd_Len;
      end
      if (issue_s && issue_wr_s) sram_data_r <= Wr_Data;
    end
  end

  sram_rd_skid #(.W(DATA_W)) u_skid (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Flush     (flush_s),
    .Push      (cap_r),
    .Push_Data (Sram_Data_Out),
    .Pop       (Rd_Ready),
    .Head      (Rd_Data),
    .Count     (skid_count_s)
  );

  assign Cmd_Ready    = (state_r == IDLE);
  assign Wr_Ready     = (state_r == WRITE) && (rem_r != LEN_ZERO);
  assign Rd_Valid     = (skid_count_s != 2'd0);
  assign Done         = done_r;
  assign Sram_Addr    = sram_addr_r;
  assign Sram_RW      = sram_rw_r;
  assign Sram_En      = sram_en_r;
  assign Sram_Data_In = sram_data_r;

endmodule

// File: tb/tb_sram_operand_master.sv
// Bench for sram_operand_master: behavioural SRAM, burst vector table and a
// read-data scoreboard fed from a shadow copy of everything written.
module tb_sram_operand_master;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Cmd_Valid, Cmd_Ready, Cmd_Write;
  logic [14:0] Cmd_Addr;
  logic [15:0] Cmd_Len;
  logic        Wr_Valid, Wr_Ready;
  logic [7:0]  Wr_Data;
  logic        Rd_Valid, Rd_Ready;
  logic [7:0]  Rd_Data;
  logic        Done;
  logic [14:0] Sram_Addr;
  logic        Sram_RW, Sram_En;
  logic [7:0]  Sram_Data_In;
  logic [7:0]  Sram_Data_Out = 8'h00;
`ifdef SRAM_MASTER_ABORT_EN
  logic        Abort;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] mem    [0:32767];
  logic [7:0] shadow [0:32767];
  logic [7:0] sb [$];

  typedef struct {
    logic        wr;
    logic [14:0] addr;
    logic [15:0] len;
    logic [7:0]  seed;
    int          rdy;          // 0 always ready, 1 pattern 1,0,0, 2 random
    int          exp_first_en; // cycle of first Sram_En after accept
    int          exp_lat;      // cycle of first Rd_Valid after accept
    bit          exp_pause;    // Sram_En must stall at least once
  } vec_t;
  vec_t vecs [8];

  always #5 Clk = ~Clk;

  // SRAM model: Data_Out valid only in the cycle after a read-enabled cycle
  always @(posedge Clk) begin
    if (Sram_En && Sram_RW) begin
      mem[Sram_Addr] <= Sram_Data_In;
      Sram_Data_Out  <= 8'h00;
    end else if (Sram_En) begin
      Sram_Data_Out <= mem[Sram_Addr];
    end else begin
      Sram_Data_Out <= 8'h00;
    end
  end

  sram_operand_master dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Write(Cmd_Write),
    .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len),
    .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Wr_Data(Wr_Data),
    .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready), .Rd_Data(Rd_Data),
    .Done(Done),
    .Sram_Addr(Sram_Addr), .Sram_RW(Sram_RW), .Sram_En(Sram_En),
    .Sram_Data_In(Sram_Data_In), .Sram_Data_Out(Sram_Data_Out)
`ifdef SRAM_MASTER_ABORT_EN
    , .Abort(Abort)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy_val(input int p, input int k);
    case (p)
      0:       return 1'b1;
      1:       return (k % 3 == 0);
      default: return 1'($urandom_range(1, 0));
    endcase
  endfunction

  task automatic reset_checks();
    chk("rst_cmd_ready", Cmd_Ready, 1);
    chk("rst_wr_ready", Wr_Ready, 0);
    chk("rst_rd_valid", Rd_Valid, 0);
    chk("rst_rd_data", Rd_Data, 0);
    chk("rst_done", Done, 0);
    chk("rst_sram_en", Sram_En, 0);
    chk("rst_sram_rw", Sram_RW, 0);
    chk("rst_sram_addr", Sram_Addr, 0);
    chk("rst_sram_din", Sram_Data_In, 0);
  endtask

  task automatic run_burst(input vec_t v);
    int nen = 0, first_en = -1, last_en = -1, done_k = -1;
    int first_v = -1, first_hs = -1, last_hs = -1, wi = 0;
    logic [14:0] a;
    logic [7:0]  e8, prev_data = 8'h00;
    logic        prev_hold = 1'b0, prev_ready = 1'b1, ready_at_done = 1'b0;
    @(negedge Clk);
    chk("cmd_ready_idle", Cmd_Ready, 1);
    Cmd_Valid = 1'b1; Cmd_Write = v.wr; Cmd_Addr = v.addr; Cmd_Len = v.len;
    Wr_Valid = 1'b0; Rd_Ready = rdy_val(v.rdy, 0);
    if (!v.wr) begin
      for (int i = 0; i < int'(v.len); i++) begin
        a = v.addr + i[14:0];
        sb.push_back(shadow[a]);
      end
    end
    for (int k = 1; k <= 400 && done_k < 0; k++) begin
      @(negedge Clk);
      Cmd_Valid = 1'b0;
      if (Sram_En) begin
        a = v.addr + nen[14:0];
        chk("sram_addr", Sram_Addr, a);
        chk("sram_rw", Sram_RW, v.wr);
        e8 = v.seed + nen[7:0];
        if (v.wr) chk("sram_wdata", Sram_Data_In, e8);
        if (first_en < 0) first_en = k;
        last_en = k;
        nen++;
      end
      if (Rd_Valid && first_v < 0) first_v = k;
      if (prev_hold) begin
        chk("rd_valid_hold", Rd_Valid, 1);
        chk("rd_data_hold", Rd_Data, prev_data);
      end
      if (Done) begin
        done_k = k;
        ready_at_done = Cmd_Ready;
      end else begin
        prev_ready = Cmd_Ready;
        Rd_Ready = rdy_val(v.rdy, k);
        if (v.wr && wi < int'(v.len)) begin
          Wr_Valid = 1'b1;
          Wr_Data  = v.seed + wi[7:0];
          if (Wr_Ready) begin
            a = v.addr + wi[14:0];
            shadow[a] = Wr_Data;
            wi++;
          end
        end else begin
          Wr_Valid = 1'b0;
        end
        if (Rd_Valid && Rd_Ready) begin
          if (sb.size() == 0) chk("rd_extra_byte", 1, 0);
          else begin
            e8 = sb.pop_front();
            chk("rd_data", Rd_Data, e8);
          end
          if (first_hs < 0) first_hs = k;
          last_hs = k;
          prev_hold = 1'b0;
        end else begin
          prev_hold = Rd_Valid;
          prev_data = Rd_Data;
        end
      end
    end
    Wr_Valid = 1'b0; Rd_Ready = 1'b0;
    if (done_k < 0) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("en_count", nen, v.len);
      chk("cmd_ready_with_done", ready_at_done, 1);
      if (v.len == 16'd0) begin
        chk("done_lat_len0", done_k, 1);
      end else begin
        chk("cmd_ready_before_done", prev_ready, 0);
        chk("first_en", first_en, v.exp_first_en);
        if (v.wr) chk("wr_done_lat", done_k, last_en + 1);
        else begin
          chk("first_rd_valid", first_v, v.exp_lat);
          chk("rd_done_lat", done_k, last_hs + 1);
          chk("sb_empty", sb.size(), 0);
          if (v.rdy == 0) chk("rd_sustain", last_hs - first_hs + 1, v.len);
        end
        if (v.wr || v.rdy == 0) chk("en_back_to_back", last_en - first_en + 1, v.len);
        if (v.exp_pause) chk("en_paused", (last_en - first_en + 1) > int'(v.len), 1);
      end
      if (v.wr) begin
        for (int i = 0; i < int'(v.len); i++) begin
          a = v.addr + i[14:0];
          chk("sram_content", mem[a], shadow[a]);
        end
      end
    end
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    Cmd_Valid = 1'b0; Cmd_Write = 1'b0; Cmd_Addr = 15'h0000; Cmd_Len = 16'd0;
    Wr_Valid = 1'b0; Wr_Data = 8'h00; Rd_Ready = 1'b0;
`ifdef SRAM_MASTER_ABORT_EN
    Abort = 1'b0;
`endif
    vecs[0] = '{1'b1, 15'h0010, 16'd4, 8'hA1, 0, 2, -1, 1'b0};
    vecs[1] = '{1'b0, 15'h0010, 16'd4, 8'h00, 0, 1, 3, 1'b0};
    vecs[2] = '{1'b1, 15'h7FFE, 16'd3, 8'h51, 0, 2, -1, 1'b0};
    vecs[3] = '{1'b0, 15'h7FFE, 16'd3, 8'h00, 2, 1, 3, 1'b0};
    vecs[4] = '{1'b1, 15'h0100, 16'd8, 8'h30, 0, 2, -1, 1'b0};
    vecs[5] = '{1'b0, 15'h0100, 16'd8, 8'h00, 1, 1, 3, 1'b1};
    vecs[6] = '{1'b1, 15'h0200, 16'd0, 8'h77, 0, -1, -1, 1'b0};
    vecs[7] = '{1'b0, 15'h0200, 16'd0, 8'h00, 0, -1, -1, 1'b0};

    repeat (2) @(negedge Clk);
    reset_checks();
    Rst_n = 1'b1;
    for (int t = 0; t < 8; t++) run_burst(vecs[t]);

    // Reset in the middle of a stalled read burst
    @(negedge Clk);
    Rd_Ready = 1'b0; Cmd_Valid = 1'b1; Cmd_Write = 1'b0; Cmd_Addr = 15'h0100; Cmd_Len = 16'd8;
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    repeat (3) @(negedge Clk);
    chk("pre_reset_rd_valid", Rd_Valid, 1);
    #2 Rst_n = 1'b0;
    #1 reset_checks();
    @(negedge Clk);
    Rst_n = 1'b1;

`ifdef SRAM_MASTER_ABORT_EN
    @(negedge Clk);
    Cmd_Valid = 1'b1; Cmd_Write = 1'b0; Cmd_Addr = 15'h0100; Cmd_Len = 16'd8;
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    repeat (3) @(negedge Clk);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    chk("abort_done", Done, 1);
    chk("abort_rd_valid", Rd_Valid, 0);
    chk("abort_cmd_ready", Cmd_Ready, 1);
    chk("abort_sram_en", Sram_En, 0);
`endif

    run_burst(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
